// File: rtl/bus_wire.sv
// Shared bus types: slave index, master FSM state
// and the request bundle carried to a slave.
package bus_wire;

    typedef enum logic [1:0] {
        IRAM  = 2'd0,
        DRAM  = 2'd1,
        TIMER = 2'd2,
        NONE  = 2'd3
    } slv_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } mst_st_e;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Memory map configuration for the CPU bus.
// Window bases and exclusive tops shared by bus blocks.
package mem_arbiter_pkg;

    localparam logic [31:0] CFG_IRAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] CFG_IRAM_TOP   = 32'h0010_0000;
    localparam logic [31:0] CFG_DRAM_BASE  = 32'h0010_0000;
    localparam logic [31:0] CFG_DRAM_TOP   = 32'h0020_0000;
    localparam logic [31:0] CFG_TIMER_BASE = 32'h0020_0000;
    localparam logic [31:0] CFG_TIMER_TOP  = 32'h0020_0010;
    localparam logic [31:0] CFG_UART_BASE  = 32'h1000_0000;
    localparam logic [31:0] CFG_UART_TOP   = 32'h1000_0004;

endpackage

// File: rtl/mem_arbiter_addr_decode.sv
// Address decoder: maps a bus address to a slave index.
// The uart window shares the iram slave port.
module addr_decode
    import bus_wire::*;
#(
    parameter logic [31:0] IRAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] IRAM_TOP   = 32'h0010_0000,
    parameter logic [31:0] DRAM_BASE  = 32'h0010_0000,
    parameter logic [31:0] DRAM_TOP   = 32'h0020_0000,
    parameter logic [31:0] TIMER_BASE = 32'h0020_0000,
    parameter logic [31:0] TIMER_TOP  = 32'h0020_0010,
    parameter logic [31:0] UART_BASE  = 32'h1000_0000,
    parameter logic [31:0] UART_TOP   = 32'h1000_0004
) (
    input  logic [31:0] addr,
    output slv_e        slv
);

    // Offset-from-base compare avoids constant-range warnings at base 0.
    function automatic logic in_win(
        input logic [31:0] a,
        input logic [31:0] base,
        input logic [31:0] top
    );
        return (a - base) < (top - base);
    endfunction

    logic hit_iram;
    logic hit_dram;
    logic hit_timer;
    logic hit_uart;

    // Window hits and resulting slave selection.
    always_comb begin
        hit_iram  = in_win(addr, IRAM_BASE, IRAM_TOP);
        hit_dram  = in_win(addr, DRAM_BASE, DRAM_TOP);
        hit_timer = in_win(addr, TIMER_BASE, TIMER_TOP);
        hit_uart  = in_win(addr, UART_BASE, UART_TOP);
        slv = NONE;
        unique case (1'b1)
            hit_iram:  slv = IRAM;
            hit_dram:  slv = DRAM;
            hit_timer: slv = TIMER;
            hit_uart:  slv = IRAM;
            default:   slv = NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, three-slave interconnect for the CPU i/d ports.
// Same-cycle pass-through; losers are parked and replayed.
module mem_arbiter
    import bus_wire::*;
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] IRAM_BASE  = CFG_IRAM_BASE,
    parameter logic [31:0] IRAM_TOP   = CFG_IRAM_TOP,
    parameter logic [31:0] DRAM_BASE  = CFG_DRAM_BASE,
    parameter logic [31:0] DRAM_TOP   = CFG_DRAM_TOP,
    parameter logic [31:0] TIMER_BASE = CFG_TIMER_BASE,
    parameter logic [31:0] TIMER_TOP  = CFG_TIMER_TOP,
    parameter logic [31:0] UART_BASE  = CFG_UART_BASE,
    parameter logic [31:0] UART_TOP   = CFG_UART_TOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  m_valid,
    input  logic [1:0]  m_instr,
    input  logic [31:0] m_addr  [2],
    input  logic [31:0] m_wdata [2],
    input  logic [3:0]  m_wstrb [2],
    output logic [31:0] m_rdata [2],
    output logic [1:0]  m_ready,
    output logic [2:0]  s_valid,
    output logic [2:0]  s_instr,
    output logic [31:0] s_addr  [3],
    output logic [31:0] s_wdata [3],
    output logic [3:0]  s_wstrb [3],
    input  logic [31:0] s_rdata [3],
    input  logic [2:0]  s_ready,
    output logic [1:0]  dec_err
);

    localparam logic [31:0] SLV_BASE [3] = '{IRAM_BASE, DRAM_BASE, TIMER_BASE};

    slv_e    dec      [2];
    mst_st_e state    [2];
    mst_st_e state_nx [2];
    req_t    pend_q   [2];
    slv_e    slv_q    [2];
    logic [2:0] busy_q;
    logic [2:0] owner_q;
    logic       last_q;

    req_t       live     [2];
    logic [1:0] want;
    slv_e       want_slv [2];
    req_t       want_req [2];
    logic [1:0] issue;
    logic [1:0] done;
    logic       conflict;
    logic       win;
    logic [3:0] busy_x;
    logic [3:0] owner_x;
    logic [3:0] rdy_x;

    for (genvar g = 0; g < 2; g++) begin : g_dec
        addr_decode #(
            .IRAM_BASE  (IRAM_BASE),
            .IRAM_TOP   (IRAM_TOP),
            .DRAM_BASE  (DRAM_BASE),
            .DRAM_TOP   (DRAM_TOP),
            .TIMER_BASE (TIMER_BASE),
            .TIMER_TOP  (TIMER_TOP),
            .UART_BASE  (UART_BASE),
            .UART_TOP   (UART_TOP)
        ) u_dec (
            .addr (m_addr[g]),
            .slv  (dec[g])
        );
    end

    assign busy_x  = {1'b1, busy_q};
    assign owner_x = {1'b0, owner_q};
    assign rdy_x   = {1'b0, s_ready};

    // Pick each master's candidate request and resolve the grant.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            live[m] = '{
                instr: m_instr[m],
                addr:  m_addr[m],
                wdata: m_wdata[m],
                wstrb: m_wstrb[m]
            };
            want[m]     = 1'b0;
            want_slv[m] = NONE;
            want_req[m] = live[m];
            if (rst) begin
                if (state[m] == ST_IDLE && m_valid[m] && dec[m] != NONE) begin
                    want[m]     = 1'b1;
                    want_slv[m] = dec[m];
                end else if (state[m] == ST_PEND) begin
                    want[m]     = 1'b1;
                    want_slv[m] = slv_q[m];
                    want_req[m] = pend_q[m];
                end
            end
        end
        conflict = want[0] && want[1] && (want_slv[0] == want_slv[1]);
        if (state[0] == ST_PEND && state[1] != ST_PEND) begin
            win = 1'b0;
        end else if (state[1] == ST_PEND && state[0] != ST_PEND) begin
            win = 1'b1;
        end else begin
            win = ~last_q;
        end
        for (int m = 0; m < 2; m++) begin
            issue[m] = want[m] && !busy_x[want_slv[m]]
                     && (!conflict || win == 1'(m));
        end
    end

    // Drive slave ports from whichever master was granted.
    always_comb begin
        s_valid = '0;
        s_instr = '0;
        for (int s = 0; s < 3; s++) begin
            s_addr[s]  = '0;
            s_wdata[s] = '0;
            s_wstrb[s] = '0;
        end
        for (int m = 0; m < 2; m++) begin
            if (issue[m]) begin
                s_valid[want_slv[m]] = 1'b1;
                s_instr[want_slv[m]] = want_req[m].instr;
                s_addr[want_slv[m]]  = want_req[m].addr ^ SLV_BASE[want_slv[m]];
                s_wdata[want_slv[m]] = want_req[m].wdata;
                s_wstrb[want_slv[m]] = want_req[m].wstrb;
            end
        end
    end

    // Route slave responses and decode errors back to the masters.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            done[m]    = 1'b0;
            m_ready[m] = 1'b0;
            m_rdata[m] = '0;
            dec_err[m] = 1'b0;
            if (rst) begin
                if (state[m] == ST_WAIT && rdy_x[slv_q[m]]
                    && busy_x[slv_q[m]] && owner_x[slv_q[m]] == 1'(m)) begin
                    done[m]    = 1'b1;
                    m_ready[m] = 1'b1;
                    m_rdata[m] = s_rdata[slv_q[m]];
                end
                if (state[m] == ST_ERR) begin
                    m_ready[m] = 1'b1;
                    dec_err[m] = 1'b1;
                end
            end
        end
    end

    // Per-master next-state logic.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            state_nx[m] = state[m];
            unique case (state[m])
                ST_IDLE: begin
                    if (m_valid[m]) begin
                        if (dec[m] == NONE) begin
                            state_nx[m] = ST_ERR;
                        end else if (issue[m]) begin
                            state_nx[m] = ST_WAIT;
                        end else begin
                            state_nx[m] = ST_PEND;
                        end
                    end
                end
                ST_PEND: if (issue[m]) state_nx[m] = ST_WAIT;
                ST_WAIT: if (done[m]) state_nx[m] = ST_IDLE;
                ST_ERR:  state_nx[m] = ST_IDLE;
                default: state_nx[m] = ST_IDLE;
            endcase
        end
    end

    // State, parked request, slave busy/owner and fairness flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                state[m]  <= ST_IDLE;
                pend_q[m] <= '0;
                slv_q[m]  <= IRAM;
            end
            busy_q  <= '0;
            owner_q <= '0;
            last_q  <= 1'b0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                state[m] <= state_nx[m];
                if (state[m] == ST_IDLE && m_valid[m] && dec[m] != NONE) begin
                    pend_q[m] <= live[m];
                    slv_q[m]  <= dec[m];
                end
            end
            for (int s = 0; s < 3; s++) begin
                if (s_ready[s]) busy_q[s] <= 1'b0;
            end
            for (int m = 0; m < 2; m++) begin
                if (issue[m]) begin
                    busy_q[want_slv[m]]  <= 1'b1;
                    owner_q[want_slv[m]] <= 1'(m);
                end
            end
            if (conflict && |issue) last_q <= win;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with a
// per-master response scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_valid;
    logic [1:0]  m_instr;
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    logic [31:0] m_rdata [2];
    logic [1:0]  m_ready;
    logic [2:0]  s_valid;
    logic [2:0]  s_instr;
    logic [31:0] s_addr  [3];
    logic [31:0] s_wdata [3];
    logic [3:0]  s_wstrb [3];
    logic [31:0] s_rdata [3];
    logic [2:0]  s_ready;
    logic [1:0]  dec_err;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_i [$];
    exp_t sb_d [$];
    int   total = 0;
    int   pass  = 0;

    mem_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .m_valid (m_valid),
        .m_instr (m_instr),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .s_valid (s_valid),
        .s_instr (s_instr),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .s_ready (s_ready),
        .dec_err (dec_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every m_ready must match the oldest expectation of its master.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (m_ready[m] === 1'b1) begin
                exp_t e;
                logic got;
                got = 1'b0;
                e   = '0;
                if (m == 0 && sb_i.size() != 0) begin
                    e = sb_i.pop_front(); got = 1'b1;
                end else if (m == 1 && sb_d.size() != 0) begin
                    e = sb_d.pop_front(); got = 1'b1;
                end
                total++;
                if (!got)
                    $display("FAIL sb_unexpected m%0d got rdata %h err %b want no response", m, m_rdata[m], dec_err[m]);
                else if ({m_rdata[m], dec_err[m]} !== {e.data, e.err})
                    $display("FAIL sb_resp m%0d got %h/%b want %h/%b", m, m_rdata[m], dec_err[m], e.data, e.err);
                else
                    pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic clr_m();
        m_valid = '0;
        m_instr = '0;
        for (int m = 0; m < 2; m++) begin
            m_addr[m] = '0; m_wdata[m] = '0; m_wstrb[m] = '0;
        end
    endtask

    task automatic clr_s();
        s_ready = '0;
        for (int s = 0; s < 3; s++) s_rdata[s] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clr_m();
        clr_s();
        tick(); tick();
        half();
        total++; if (s_valid !== 3'b000) $display("FAIL rst_svalid got %b want 000", s_valid); else pass++;
        total++; if (m_ready !== 2'b00) $display("FAIL rst_mready got %b want 00", m_ready); else pass++;
        total++; if (dec_err !== 2'b00) $display("FAIL rst_decerr got %b want 00", dec_err); else pass++;
        total++; if (m_rdata[1] !== 32'h0) $display("FAIL rst_rdata got %h want 0", m_rdata[1]); else pass++;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        m_valid[0] = 1'b1; m_instr[0] = 1'b1; m_addr[0] = 32'h0000_0100;
        sb_i.push_back('{data: 32'hCAFE_0001, err: 1'b0});
        half();
        total++; if (s_valid !== 3'b001) $display("FAIL fetch_sv got %b want 001", s_valid); else pass++;
        total++; if (s_addr[0] !== 32'h100) $display("FAIL fetch_addr got %h want 100", s_addr[0]); else pass++;
        total++; if (s_instr[0] !== 1'b1) $display("FAIL fetch_instr got %b want 1", s_instr[0]); else pass++;
        tick();
        clr_m();
        half();
        total++; if (s_valid !== 3'b000) $display("FAIL fetch_sv_gone got %b want 000", s_valid); else pass++;
        total++; if (m_ready !== 2'b00) $display("FAIL fetch_early_rdy got %b want 00", m_ready); else pass++;
        tick();
        s_ready[0] = 1'b1; s_rdata[0] = 32'hCAFE_0001;
        half();
        total++; if (m_ready !== 2'b01) $display("FAIL fetch_rdy got %b want 01", m_ready); else pass++;
        tick();
        clr_s();
    endtask

    task automatic test_conflict();
        m_valid = 2'b11;
        m_instr[0] = 1'b1; m_addr[0] = 32'h0010_0000;
        m_addr[1] = 32'h0010_0004; m_wdata[1] = 32'h1234_5678; m_wstrb[1] = 4'hF;
        sb_d.push_back('{data: 32'hD0D0_0001, err: 1'b0});
        sb_i.push_back('{data: 32'hD0D0_0002, err: 1'b0});
        half();
        total++; if (s_valid !== 3'b010) $display("FAIL cf_sv got %b want 010", s_valid); else pass++;
        total++; if (s_addr[1] !== 32'h4) $display("FAIL cf_addr got %h want 4", s_addr[1]); else pass++;
        total++; if (s_wstrb[1] !== 4'hF) $display("FAIL cf_wstrb got %h want f", s_wstrb[1]); else pass++;
        total++; if (s_wdata[1] !== 32'h1234_5678) $display("FAIL cf_wdata got %h want 12345678", s_wdata[1]); else pass++;
        tick();
        clr_m();
        half();
        total++; if (s_valid !== 3'b000) $display("FAIL cf_pend_sv got %b want 000", s_valid); else pass++;
        tick();
        s_ready[1] = 1'b1; s_rdata[1] = 32'hD0D0_0001;
        half();
        total++; if (s_valid !== 3'b000) $display("FAIL cf_noreissue got %b want 000", s_valid); else pass++;
        tick();
        clr_s();
        half();
        total++; if (s_valid !== 3'b010) $display("FAIL cf_replay_sv got %b want 010", s_valid); else pass++;
        total++; if (s_addr[1] !== 32'h0) $display("FAIL cf_replay_addr got %h want 0", s_addr[1]); else pass++;
        total++; if (s_instr[1] !== 1'b1) $display("FAIL cf_replay_instr got %b want 1", s_instr[1]); else pass++;
        total++; if (s_wstrb[1] !== 4'h0) $display("FAIL cf_replay_wstrb got %h want 0", s_wstrb[1]); else pass++;
        tick();
        s_ready[1] = 1'b1; s_rdata[1] = 32'hD0D0_0002;
        tick();
        clr_s();
        tick();
    endtask

    task automatic test_alternate();
        m_valid = 2'b11;
        m_instr[0] = 1'b1; m_addr[0] = 32'h0010_0008;
        m_addr[1] = 32'h0010_000C;
        sb_i.push_back('{data: 32'hA1A1_0001, err: 1'b0});
        sb_d.push_back('{data: 32'hA1A1_0002, err: 1'b0});
        half();
        total++; if (s_valid !== 3'b010) $display("FAIL alt_sv got %b want 010", s_valid); else pass++;
        total++; if (s_addr[1] !== 32'h8) $display("FAIL alt_addr got %h want 8", s_addr[1]); else pass++;
        total++; if (s_instr[1] !== 1'b1) $display("FAIL alt_instr got %b want 1", s_instr[1]); else pass++;
        tick();
        clr_m();
        s_ready[1] = 1'b1; s_rdata[1] = 32'hA1A1_0001;
        tick();
        clr_s();
        half();
        total++; if (s_valid !== 3'b010) $display("FAIL alt_replay_sv got %b want 010", s_valid); else pass++;
        total++; if (s_addr[1] !== 32'hC) $display("FAIL alt_replay_addr got %h want c", s_addr[1]); else pass++;
        tick();
        s_ready[1] = 1'b1; s_rdata[1] = 32'hA1A1_0002;
        tick();
        clr_s();
        tick();
    endtask

    task automatic test_concurrent();
        m_valid = 2'b11;
        m_instr[0] = 1'b1; m_addr[0] = 32'h0000_0040;
        m_addr[1] = 32'h0020_0008;
        sb_i.push_back('{data: 32'h5555_0040, err: 1'b0});
        sb_d.push_back('{data: 32'h7777_0008, err: 1'b0});
        half();
        total++; if (s_valid !== 3'b101) $display("FAIL cc_sv got %b want 101", s_valid); else pass++;
        total++; if (s_addr[0] !== 32'h40) $display("FAIL cc_iaddr got %h want 40", s_addr[0]); else pass++;
        total++; if (s_addr[2] !== 32'h8) $display("FAIL cc_taddr got %h want 8", s_addr[2]); else pass++;
        tick();
        clr_m();
        s_ready[2] = 1'b1; s_rdata[2] = 32'h7777_0008;
        half();
        total++; if (m_ready !== 2'b10) $display("FAIL cc_dready got %b want 10", m_ready); else pass++;
        tick();
        clr_s();
        s_ready[0] = 1'b1; s_rdata[0] = 32'h5555_0040;
        tick();
        clr_s();
        tick();
    endtask

    task automatic test_unmapped();
        m_valid[1] = 1'b1; m_addr[1] = 32'h3000_0000;
        sb_d.push_back('{data: 32'h0, err: 1'b1});
        half();
        total++; if (s_valid !== 3'b000) $display("FAIL um_sv got %b want 000", s_valid); else pass++;
        total++; if (m_ready !== 2'b00) $display("FAIL um_early got %b want 00", m_ready); else pass++;
        tick();
        clr_m();
        half();
        total++; if (dec_err !== 2'b10) $display("FAIL um_decerr got %b want 10", dec_err); else pass++;
        total++; if (s_valid !== 3'b000) $display("FAIL um_sv2 got %b want 000", s_valid); else pass++;
        tick();
        half();
        total++; if (m_ready !== 2'b00) $display("FAIL um_once got %b want 00", m_ready); else pass++;
        tick();
    endtask

    task automatic test_mid_reset();
        m_valid = 2'b11;
        m_addr[0] = 32'h0010_0014;
        m_addr[1] = 32'h0010_0010;
        half();
        total++; if (s_valid !== 3'b010) $display("FAIL mr_sv got %b want 010", s_valid); else pass++;
        total++; if (s_addr[1] !== 32'h10) $display("FAIL mr_addr got %h want 10", s_addr[1]); else pass++;
        tick();
        clr_m();
        tick();
        rst = 1'b0;
        tick();
        half();
        total++; if (s_valid !== 3'b000) $display("FAIL mr_rst_sv got %b want 000", s_valid); else pass++;
        total++; if (m_ready !== 2'b00) $display("FAIL mr_rst_rdy got %b want 00", m_ready); else pass++;
        total++; if (s_addr[1] !== 32'h0) $display("FAIL mr_rst_addr got %h want 0", s_addr[1]); else pass++;
        tick();
        rst = 1'b1;
        half();
        total++; if (s_valid !== 3'b000) $display("FAIL mr_no_replay got %b want 000", s_valid); else pass++;
        tick();
        s_ready[1] = 1'b1; s_rdata[1] = 32'hBAD0_0BAD;
        half();
        total++; if (m_ready !== 2'b00) $display("FAIL mr_late_rdy got %b want 00", m_ready); else pass++;
        tick();
        clr_s();
        m_valid[1] = 1'b1; m_addr[1] = 32'h0010_0020;
        sb_d.push_back('{data: 32'h0000_2020, err: 1'b0});
        half();
        total++; if (s_valid !== 3'b010) $display("FAIL mr_fresh_sv got %b want 010", s_valid); else pass++;
        total++; if (s_addr[1] !== 32'h20) $display("FAIL mr_fresh_addr got %h want 20", s_addr[1]); else pass++;
        tick();
        clr_m();
        s_ready[1] = 1'b1; s_rdata[1] = 32'h0000_2020;
        tick();
        clr_s();
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_conflict();
        test_alternate();
        test_concurrent();
        test_unmapped();
        test_mid_reset();
        tick();
        half();
        total++; if (sb_i.size() != 0) $display("FAIL sb_i_left got %0d want 0", sb_i.size()); else pass++;
        total++; if (sb_d.size() != 0) $display("FAIL sb_d_left got %0d want 0", sb_d.size()); else pass++;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
